// File: rtl/intcalc_seq.sv
// Sequential integer mul/div/mod unit, one shift-add/subtract step per clock.
// Optional early exit for trivial operands: define INTCALC_FASTPATH_EN.
`timescale 1ns/1ps
module intcalc_seq #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_n;
  logic [1:0]           op;
  logic                 neg_res, neg_rem, dz;
  logic [WIDTH-1:0]     opd;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem;
  logic [CW-1:0]        cnt;

  logic                 in_signed, in_mul, in_dz, fast;
  logic [WIDTH-1:0]     abs1, abs2;
  logic                 op_mul;
  logic [WIDTH:0]       mac;
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH-1:0]     rem_step;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s, res;

  assign in_signed = ~func[2];
  assign in_mul    = (func[1:0] == 2'b00) | (func[1:0] == 2'b11);
  assign in_dz     = ~in_mul & ~|in2;
  assign abs1      = (in_signed & in1[WIDTH-1]) ? -in1 : in1;
  assign abs2      = (in_signed & in2[WIDTH-1]) ? -in2 : in2;

`ifdef INTCALC_FASTPATH_EN
  assign fast = in_dz | ~|in1 | (in_mul & ~|in2);
`else
  assign fast = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign op_mul    = (op == 2'b00) | (op == 2'b11);

  // one multiply step (add then shift right) and one restoring divide step
  always_comb begin
    mac      = {1'b0, prod[2*WIDTH-1:WIDTH]}
             + (prod[0] ? {1'b0, opd} : '0);
    trial    = {rem, prod[WIDTH-1]};
    ge       = trial >= {1'b0, opd};
    rem_step = ge ? WIDTH'(trial - {1'b0, opd})
                  : trial[WIDTH-1:0];
  end

  // sign correction and result select for the FIX cycle
  always_comb begin
    prod_s = neg_res ? -prod : prod;
    quot_s = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_s  = neg_rem ? -rem : rem;
    res    = '0;
    unique case (1'b1)
      op == 2'b00: res = prod_s[WIDTH-1:0];
      op == 2'b11: res = prod_s[2*WIDTH-1:WIDTH];
      op == 2'b01: res = dz ? '1 : quot_s;
      op == 2'b10: res = rem_s;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = fast ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
    endcase
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      opd     <= '0;
      prod    <= '0;
      rem     <= '0;
      cnt     <= '0;
      out     <= '0;
      div0    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op      <= func[1:0];
          dz      <= in_dz;
          neg_res <= in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          neg_rem <= in_signed & in1[WIDTH-1];
          cnt     <= CW'(WIDTH);
          if (in_mul) begin
            opd  <= abs1;
            prod <= fast ? '0 : {{WIDTH{1'b0}}, abs2};
            rem  <= '0;
          end else begin
            opd  <= abs2;
            prod <= fast ? '0 : {{WIDTH{1'b0}}, abs1};
            rem  <= (fast & in_dz) ? abs1 : '0;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (op_mul) begin
            prod <= {mac, prod[WIDTH-1:1]};
          end else begin
            prod <= {prod[2*WIDTH-1:WIDTH],
                     prod[WIDTH-2:0], ge};
            rem  <= rem_step;
          end
        end
        FIX: begin
          out  <= res;
          div0 <= dz;
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intcalc_seq.sv
// Scoreboard bench for intcalc_seq: random and directed ops
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_intcalc_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   func = '0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         in_ready, out_valid, div0;
  logic [W-1:0] out;

  intcalc_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .div0(div0)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [W-1:0] v;
    logic         z;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic rnd_bp = 1'b0;

  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;

  task automatic chk(string n, logic [W-1:0] act,
                     logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, want);
    end
  endtask

  function automatic exp_t model(logic [2:0] f,
                                 logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     ps = sa * sb;
    logic [63:0]     pu = ua * ub;
    logic            is_mul = (f[1:0] == 2'b00) || (f[1:0] == 2'b11);
    logic            fast;
    e.z = 1'b0;
    e.v = '0;
    e.acc = 0;
    case (f)
      3'd0: e.v = ps[31:0];
      3'd3: e.v = ps[63:32];
      3'd4: e.v = pu[31:0];
      3'd7: e.v = pu[63:32];
      3'd1: if (b == 0) begin e.v = ONES; e.z = 1'b1; end
            else if (a == MINV && b == ONES) e.v = MINV;
            else e.v = W'(sa / sb);
      3'd2: if (b == 0) begin e.v = a; e.z = 1'b1; end
            else if (a == MINV && b == ONES) e.v = '0;
            else e.v = W'(sa % sb);
      3'd5: if (b == 0) begin e.v = ONES; e.z = 1'b1; end
            else e.v = W'(ua / ub);
      default: if (b == 0) begin e.v = a; e.z = 1'b1; end
            else e.v = W'(ua % ub);
    endcase
    fast = 1'b0;
`ifdef INTCALC_FASTPATH_EN
    fast = (!is_mul && b == 0) || a == 0 || (is_mul && b == 0);
`endif
    e.lat = fast ? 1 : W + 1;
    return e;
  endfunction

  task automatic issue(logic [2:0] f, logic [W-1:0] a,
                       logic [W-1:0] b);
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1; func = f; in1 = a; in2 = b;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clock);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got 0 want 1");
    end else begin
      e = model(f, a, b);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d want 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return ONES;
      3: return MINV;
      4: return 32'h7fffffff;
      5: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // monitor: pops the scoreboard on each accepted result
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_out = '0;
  int           first_cyc = 0;
  always begin
    exp_t e;
    @(negedge clock);
    #1;
    if (reset_n && out_valid) begin
      if (!prev_hold) first_cyc = cyc;
      else begin
        chk("hold_out", out, prev_out);
        chk("hold_in_ready", W'(in_ready), '0);
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out got %h want none", out);
        end else begin
          e = q.pop_front();
          chk("result", out, e.v);
          chk("div0", W'(div0), W'(e.z));
          chk("latency", W'(first_cyc - e.acc), W'(e.lat));
        end
      end
    end
    prev_hold = reset_n && out_valid && !out_ready;
    prev_out  = out;
  end

  always @(negedge clock)
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out", out, 0);
    chk("rst_div0", W'(div0), 0);

    // abandon a DIV mid-calculation via reset
    @(negedge clock);
    in_valid = 1'b1; func = 3'd1; in1 = 100; in2 = 7;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("mid_rst_in_ready", W'(in_ready), 1);
    chk("mid_rst_out_valid", W'(out_valid), 0);
    chk("mid_rst_out", out, 0);
    issue(3'd4, 3, 5);
    drain();

    issue(3'd0, -32'sd6, 7);                 drain();
    issue(3'd3, MINV, 2);                     drain();
    issue(3'd7, MINV, 2);                     drain();
    issue(3'd1, -32'sd7, 2);                  drain();
    issue(3'd2, -32'sd7, 2);                  drain();
    issue(3'd5, ONES, 16);                    drain();
    issue(3'd6, ONES, 16);                    drain();
    issue(3'd5, 123, 0);                      drain();
    issue(3'd2, 123, 0);                      drain();
    issue(3'd1, -32'sd9, 0);                  drain();
    issue(3'd1, MINV, ONES);                  drain();
    issue(3'd2, MINV, ONES);                  drain();
    issue(3'd1, 0, 5);                        drain();
    issue(3'd0, 0, 5);                        drain();
    issue(3'd4, 77, 0);                       drain();

    // backpressure: hold the result, poke in_valid meanwhile
    out_ready = 1'b0;
    issue(3'd4, 1234, 5678);
    seen = 0;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clock);
    chk("bp_valid", W'(out_valid), 1);
    repeat (3) @(negedge clock);
    in_valid = 1'b1; func = 3'd0; in1 = 9; in2 = 9;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_in_ready", W'(in_ready), 1);
    chk("bp_out_valid", W'(out_valid), 0);
    drain();

    // back-to-back random ops, steady then with random stalls
    for (int i = 0; i < 30; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick());
    drain();
    rnd_bp = 1'b1;
    for (int i = 0; i < 30; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick());
    drain();
    rnd_bp = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intcalc_seq.md
Name: intcalc_seq

Overview:
- Parametrised, multi-cycle successor to the combinational integer mul/div/mod unit in the CPU datapath.
- Computes signed and unsigned multiply (low or high half), divide and modulo with one shift-add or shift-subtract step per clock, instead of large combinational multiplier and divider cores.
- Uses a valid/ready handshake on both input and output so the CPU control sequencer can stall on it.
- Adds high-half multiply results, defined divide-by-zero and overflow results, and a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- CW, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and func present.
- in_ready  out  1  unit idle; accepts operands when in_valid=1.
- func  in  3  000 MUL, 001 DIV, 010 MOD, 011 MULH, 100 MULU, 101 DIVU, 110 MODU, 111 MULHU.
- in1  in  WIDTH  multiplicand / dividend.
- in2  in  WIDTH  multiplier / divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- div0  out  1  result came from a DIV, MOD, DIVU or MODU with in2=0; valid only with out_valid.

Behaviour:
- Reset: reset_n sampled low on a clock edge forces the following:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, out=0, div0=0;
  - internal accumulators and counter are cleared.
- Reset mid-operation abandons the operation with no output.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch func, a dividend/multiplicand register and a divisor/multiplier register.
  - For signed ops (func[2]=0), latch the absolute values of in1 and in2, and record sign flags: result sign and remainder sign.
  - Load counter with WIDTH, then go to CALC.
- CALC:
  - in_ready=0; runs exactly WIDTH cycles, counter decrements each cycle.
  - Multiply: shift-add on a 2*WIDTH product register, 1 multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm, 1 quotient bit per cycle, MSB first, on a WIDTH+1-bit partial remainder.
  - Go to FIX when counter reaches 1.
- FIX (1 cycle):
  - Apply two's-complement sign correction:
    - product negated if sign(in1) XOR sign(in2);
    - quotient negated if the signs differ;
    - remainder takes the sign of the dividend.
  - Select the result:
    - MUL/MULU: product[WIDTH-1:0];
    - MULH/MULHU: product[2*WIDTH-1:WIDTH];
    - DIV/DIVU: quotient;
    - MOD/MODU: remainder.
  - Register the result into out, then go to DONE.
- DONE:
  - out_valid=1; out and div0 are held stable until out_ready=1.
  - On out_ready=1, go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no overlap of operations.
- Latency: input accepted at edge N; out_valid high from cycle N+WIDTH+2. With out_ready held high, throughput is one op per WIDTH+3 cycles.
- Divide by zero:
  - DIV/DIVU give quotient = all ones; MOD/MODU give remainder = in1 unmodified.
  - div0=1.
  - Normal WIDTH-cycle timing unless INTCALC_FASTPATH_EN is defined.
- Signed overflow: DIV with in1 = most-negative and in2 = -1 gives quotient = most-negative; MOD gives 0; div0=0.
- in_valid while busy is ignored; the operand source must hold its values until in_ready=1.
- Inputs are not sampled outside IDLE, so operand changes during CALC have no effect.

Optional Feature:
- Macro: INTCALC_FASTPATH_EN.
- When defined, the IDLE-state check for each case below goes directly to FIX, skipping CALC:
  - divide with in2=0;
  - any op with in1=0;
  - multiply with in2=0.
- FIX then loads the defined special result. Latency for these cases becomes 2 cycles (out_valid at N+2).
- When undefined, all ops take the full WIDTH+2 latency. Results are identical either way.

Test Plan (WIDTH=32):
- Reset: reset_n=0 for 2 cycles during CALC of DIV 100/7 -> after release in_ready=1, out_valid=0, out=0; the new op MULU 3*5 returns 15.
- Signed: MUL in1=-6, in2=7 -> out=0xFFFFFFD6. MULH in1=0x80000000, in2=2 -> out=0xFFFFFFFF. MULHU same operands -> out=1.
- Divide: DIV -7/2 -> 0xFFFFFFFD. MOD -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF. MODU same operands -> 0xF. Each with out_valid exactly 34 cycles after the accept edge.
- Boundaries:
  - DIVU 123/0 -> out=0xFFFFFFFF, div0=1.
  - MOD 123/0 -> out=123, div0=1.
  - DIV 0x80000000/0xFFFFFFFF -> out=0x80000000, div0=0.
  - With INTCALC_FASTPATH_EN, DIVU 123/0 -> out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> in_ready=1 next cycle; back-to-back ops complete correctly.
